// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Oversampling UART receiver. The serial line is sampled on a 16x baud enable
// strobe; the start bit is qualified at its midpoint, and each data bit and
// the stop bit are then taken 16 ticks apart, which places every sample near
// the centre of its bit cell.
//
// Ports
//   clk_50m    in   system clock, all state updates on its rising edge
//   rst_n      in   asynchronous active-low reset
//   rxclk_en   in   one-cycle enable strobe at 16x baud
//   rx         in   serial line, asynchronous to clk_50m, idle high
//   rdy_clr    in   one-cycle pulse acknowledging the received byte
//   data       out  last good received byte, LSB = first data bit on the line
//   rdy        out  byte available, sticky until rdy_clr
//   frame_err  out  last frame had a stop bit of 0
//   overrun    out  a byte completed while rdy was still 1, sticky until rdy_clr
//   state_dbg  out  current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Handshake: rdy rises on the clock edge that ends a good stop-bit sample and
// stays high until the consumer pulses rdy_clr. data is valid whenever rdy is
// 1 and keeps its value after rdy_clr. A rdy_clr on the same edge as a new
// completion loses: the new byte is presented with rdy=1 and overrun=0.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic [3:0] MID_START = 4'd8;
  localparam logic [3:0] LAST_SMP  = 4'd15;

  state_t               state;
  logic [3:0]           sample;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_m;
  logic                 rx_s;

  assign state_dbg = state;

  // Two-flop synchronizer. Both flops reset to the idle level so that
  // reset release never looks like a falling start edge.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receive FSM with its registered outputs. The rdy_clr clear is written
  // first so that a byte completing on the same edge overrides it.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sample    <= 4'd0;
      bit_idx   <= 3'd0;
      shreg     <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end

      if (rxclk_en) begin
        case (state)
          IDLE: begin
            // The tick that sees the low level counts as sample 1 of the
            // start bit, so the midpoint check lands 8 ticks later.
            if (!rx_s) begin
              state  <= START;
              sample <= 4'd1;
            end
          end

          START: begin
            if (sample == MID_START) begin
              if (!rx_s) begin
                state   <= DATA;
                sample  <= 4'd0;
                bit_idx <= 3'd0;
              end else begin
                // Glitch shorter than half a bit: abandon silently.
                state  <= IDLE;
                sample <= 4'd0;
              end
            end else begin
              sample <= sample + 4'd1;
            end
          end

          DATA: begin
            // Free-running 4-bit count; 15 wraps to 0 between data bits.
            sample <= sample + 4'd1;
            if (sample == LAST_SMP) begin
              shreg[bit_idx] <= rx_s;
              if (bit_idx == LAST_IDX) begin
                state  <= STOP;
                sample <= 4'd0;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end

          STOP: begin
            if (sample == LAST_SMP) begin
              // Back to IDLE whatever the line level; a line still low
              // after a framing error starts a new frame on the next tick.
              state  <= IDLE;
              sample <= 4'd0;
              if (rx_s) begin
                data      <= shreg;
                rdy       <= 1'b1;
                frame_err <= 1'b0;
                overrun   <= rdy & ~rdy_clr;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              sample <= sample + 4'd1;
            end
          end

          default: begin
            state  <= IDLE;
            sample <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx (DATA_BITS=8). rxclk_en is a 1-in-28 strobe that
// changes shortly after a rising edge; the line is driven on falling edges
// just after a tick, and outputs are read on falling edges or 1 unit after
// the rising edge that consumes a tick.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  logic       clk_50m  = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rxclk_en = 1'b0;
  logic       rx       = 1'b1;
  logic       rdy_clr  = 1'b0;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.DATA_BITS(8)) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .rxclk_en  (rxclk_en),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / strobe / watchdog ----------------
  always #10 clk_50m = ~clk_50m;

  initial begin : strobe_gen
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_50m);
      #2;
      cnt = (cnt == 27) ? 0 : cnt + 1;
      rxclk_en = (cnt == 0);
    end
  end

  initial begin : watchdog
    #1600000;
    $display("FAIL watchdog: bench still running, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_data_pop(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: expected queue empty, got data 0x%0h", tag, data);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(data), 32'(e));
    end
  endtask

  // ---------------- drivers ----------------
  // Returns just after the rising edge that consumes the n-th tick.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(negedge clk_50m); while (!rxclk_en);
      @(posedge clk_50m);
    end
  endtask

  task automatic set_rx(input logic v);
    @(negedge clk_50m);
    rx = v;
  endtask

  // Drives a full frame and returns on the falling edge where the
  // stop-sampling tick is presented (not yet consumed).
  task automatic send_frame(input logic [7:0] d, input logic stop);
    set_rx(1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(d[i]);
      wait_ticks(16);
    end
    set_rx(stop);
    wait_ticks(8);
    do @(negedge clk_50m); while (!rxclk_en);
  endtask

  task automatic complete();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m);
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [7:0] c9;

    // Reset state
    repeat (3) @(negedge clk_50m);
    check("rst_data", 32'(data), 32'h00);
    check("rst_rdy", 32'(rdy), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk_50m);
    rst_n = 1'b1;
    wait_ticks(2);

    // False start: 4 ticks low, then high again before the midpoint
    set_rx(1'b0);
    wait_ticks(4);
    #1;
    check("fs_in_start", 32'(state_dbg), 32'(ST_START));
    set_rx(1'b1);
    wait_ticks(12);
    @(negedge clk_50m);
    check("fs_state", 32'(state_dbg), 32'(ST_IDLE));
    check("fs_rdy", 32'(rdy), 32'h0);
    check("fs_data", 32'(data), 32'h00);

    // Good frame 0x55, including rdy timing around the stop tick
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    check("f55_rdy_before", 32'(rdy), 32'h0);
    complete();
    check("f55_rdy_after", 32'(rdy), 32'h1);
    check_data_pop("f55_data");
    check("f55_ferr", 32'(frame_err), 32'h0);
    check("f55_ovr", 32'(overrun), 32'h0);
    check("f55_state", 32'(state_dbg), 32'(ST_IDLE));

    // Framing error on 0xA3: data and rdy keep the 0x55 result
    send_frame(8'hA3, 1'b0);
    complete();
    check("fa3_ferr", 32'(frame_err), 32'h1);
    check("fa3_data", 32'(data), 32'h55);
    check("fa3_rdy", 32'(rdy), 32'h1);
    check("fa3_ovr", 32'(overrun), 32'h0);
    set_rx(1'b1);
    wait_ticks(2);
    @(negedge clk_50m);
    check("fa3_idle", 32'(state_dbg), 32'(ST_IDLE));
    pulse_clr();
    check("fa3_clr_rdy", 32'(rdy), 32'h0);
    check("fa3_clr_data", 32'(data), 32'h55);
    check("fa3_clr_ferr", 32'(frame_err), 32'h1);

    // 0x12 then 0x34 without acknowledge -> overrun
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    complete();
    check_data_pop("f12_data");
    check("f12_rdy", 32'(rdy), 32'h1);
    check("f12_ovr", 32'(overrun), 32'h0);
    check("f12_ferr", 32'(frame_err), 32'h0);
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1);
    complete();
    check_data_pop("f34_data");
    check("f34_rdy", 32'(rdy), 32'h1);
    check("f34_ovr", 32'(overrun), 32'h1);
    pulse_clr();
    check("f34_clr_rdy", 32'(rdy), 32'h0);
    check("f34_clr_ovr", 32'(overrun), 32'h0);
    check("f34_clr_data", 32'(data), 32'h34);
    pulse_clr();
    check("clr_idle_rdy", 32'(rdy), 32'h0);
    check("clr_idle_data", 32'(data), 32'h34);

    // rdy_clr on the completion edge of 0x7E while rdy=1
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    complete();
    check_data_pop("f33_data");
    check("f33_rdy", 32'(rdy), 32'h1);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    rdy_clr = 1'b1;
    complete();
    check("f7e_rdy", 32'(rdy), 32'h1);
    check("f7e_ovr", 32'(overrun), 32'h0);
    check_data_pop("f7e_data");
    @(negedge clk_50m);
    rdy_clr = 1'b0;

    // Reset during bit 3 of 0xC9
    c9 = 8'hC9;
    set_rx(1'b0);
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      set_rx(c9[i]);
      wait_ticks(i == 3 ? 8 : 16);
    end
    @(negedge clk_50m);
    check("c9_in_data", 32'(state_dbg), 32'(ST_DATA));
    rst_n = 1'b0;
    #1;
    check("c9_rst_data", 32'(data), 32'h00);
    check("c9_rst_rdy", 32'(rdy), 32'h0);
    check("c9_rst_ferr", 32'(frame_err), 32'h0);
    check("c9_rst_ovr", 32'(overrun), 32'h0);
    check("c9_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (3) @(negedge clk_50m);
    rx = 1'b1;
    @(negedge clk_50m);
    rst_n = 1'b1;
    wait_ticks(20);
    @(negedge clk_50m);
    check("c9_post_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("c9_post_rdy", 32'(rdy), 32'h0);

    // Next full frame after the aborted one
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    complete();
    check_data_pop("f81_data");
    check("f81_rdy", 32'(rdy), 32'h1);
    check("f81_ovr", 32'(overrun), 32'h0);
    check("f81_ferr", 32'(frame_err), 32'h0);
    set_rx(1'b1);
    wait_ticks(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..8.
REQ-002 SHALL have port clk_50m  input  1  system clock, 50 MHz; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rxclk_en  input  1  one-cycle enable strobe at 16x baud, from the baud generator.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clk_50m, idle high.
REQ-006 SHALL have port rdy_clr  input  1  one-cycle pulse acknowledging the received byte.
REQ-007 SHALL have port data  output  DATA_BITS  last good received byte, LSB = first data bit on the line.
REQ-008 SHALL have port rdy  output  1  byte available; sticky until rdy_clr.
REQ-009 SHALL have port frame_err  output  1  last frame had a stop bit of 0.
REQ-010 SHALL have port overrun  output  1  a byte completed while rdy was already 1; sticky until rdy_clr.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer clocked every clk_50m cycle; both flops set to 1 by reset; all state logic uses the synchronized value rx_s.
REQ-012 SHALL advance the FSM and the 4-bit sample counter only in cycles where rxclk_en=1; with rxclk_en=0, FSM, counters and shift register hold.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 In IDLE, rxclk_en=1 with rx_s=0: go to START with sample=1. Otherwise remain in IDLE.
REQ-015 In START, increment sample each tick. At the tick where sample=8 (mid start bit):
- rx_s=0: go to DATA with sample=0 and bit index=0.
- rx_s=1: false start; return to IDLE with no output change.
REQ-016 In DATA, increment sample each tick, wrapping 15->0. At the tick where sample=15, shift rx_s into the shift register at bit[bit index], LSB first.
REQ-017 After DATA_BITS samples have been taken, go to STOP with sample=0.
REQ-018 In STOP, increment sample each tick. At the tick where sample=15, sample the stop bit and return to IDLE on the same tick.
REQ-019 On a stop bit of 1:
- data<=shift register, rdy<=1, frame_err<=0.
- overrun<=1 if rdy was already 1 and rdy_clr is not asserted in that same cycle.
REQ-020 On a stop bit of 0:
- frame_err<=1.
- data, rdy and overrun are unchanged.
REQ-021 Outputs SHALL be registered. rdy, data and frame_err update on the clk_50m edge that ends the stop-sampling tick, i.e. one clock after that tick is presented.
REQ-022 rdy_clr=1 SHALL clear rdy and overrun on the next edge. If rdy_clr coincides with a byte completion, completion wins: rdy=1, overrun=0, data=new byte.
REQ-023 rdy_clr with rdy=0 SHALL have no effect. data SHALL hold its value after rdy_clr.
REQ-024 SHALL return to IDLE after STOP regardless of rx_s. A line held low after a framing error retriggers START at the next tick.
REQ-025 Sample counter and bit index SHALL wrap only as stated; there are no other terminal states.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately, regardless of clock, force:
- state=IDLE, sample=0, bit index=0;
- shift register=0, data=0;
- rdy=0, frame_err=0, overrun=0;
- both synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame. After release, reception restarts only on a new falling edge seen in IDLE.
REQ-028 Release of rst_n SHALL take effect on the first clk_50m edge after deassertion; there is no other start-up delay.

Verification
REQ-029 Bench SHALL drive rxclk_en as a 1-in-28-cycle strobe and the cases below:
- Frame 0x55 with stop=1 -> data=0x55, rdy=1, frame_err=0, overrun=0; rdy rises one clock after the stop-sample tick.
- rx low for 4 ticks, then high -> FSM back in IDLE; rdy=0, data unchanged (0x00 after reset).
- Frame 0xA3 with stop=0 after a good 0x55 -> frame_err=1, data=0x55, rdy unchanged.
- Frames 0x12 then 0x34 with no rdy_clr -> data=0x34, rdy=1, overrun=1. A subsequent rdy_clr -> rdy=0, overrun=0, data=0x34.
- rdy_clr pulsed on the same cycle as completion of 0x7E while rdy=1 -> rdy=1, overrun=0, data=0x7E.
- rst_n pulsed low during bit 3 of 0xC9 -> all outputs 0 at once. The next full frame 0x81 -> data=0x81, rdy=1.
